// File: rtl/alu_arb.sv
// alu_arb: two requesters share one ALU, one operation in flight at a time.
// Define ALU_ARB_RR_EN for round-robin arbitration; default is fixed priority to requester 0.

`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 4
`endif
`ifndef ALU_AND
`define ALU_AND  4'd0
`define ALU_OR   4'd1
`define ALU_XOR  4'd2
`define ALU_ADD  4'd3
`define ALU_SUB  4'd4
`define ALU_SLL  4'd5
`define ALU_SRL  4'd6
`define ALU_SRA  4'd7
`define ALU_SLT  4'd8
`define ALU_SLTU 4'd9
`endif

module alu (
  input  logic [`ALU_OP_WIDTH-1:0] op_i,
  input  logic [`CPU_WIDTH-1:0]    src1_i,
  input  logic [`CPU_WIDTH-1:0]    src2_i,
  output logic [`CPU_WIDTH-1:0]    res_o,
  output logic                     zero_o
);
  logic [4:0] shamt_s;
  assign shamt_s = src2_i[4:0];

  // combinational result select; unknown opcodes give zero
  always_comb begin
    res_o = {`CPU_WIDTH{1'b0}};
    case (op_i)
      `ALU_AND:  res_o = src1_i & src2_i;
      `ALU_OR:   res_o = src1_i | src2_i;
      `ALU_XOR:  res_o = src1_i ^ src2_i;
      `ALU_ADD:  res_o = src1_i + src2_i;
      `ALU_SUB:  res_o = src1_i - src2_i;
      `ALU_SLL:  res_o = src1_i << shamt_s;
      `ALU_SRL:  res_o = src1_i >> shamt_s;
      `ALU_SRA:  res_o = $unsigned($signed(src1_i) >>> shamt_s);
      `ALU_SLT:  res_o = {{(`CPU_WIDTH-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
      `ALU_SLTU: res_o = {{(`CPU_WIDTH-1){1'b0}}, (src1_i < src2_i)};
      default:   res_o = {`CPU_WIDTH{1'b0}};
    endcase
  end

  assign zero_o = (res_o == {`CPU_WIDTH{1'b0}});
endmodule

module alu_arb (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [`ALU_OP_WIDTH-1:0] req0_op,
  input  logic [`CPU_WIDTH-1:0]    req0_src1,
  input  logic [`CPU_WIDTH-1:0]    req0_src2,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic [`ALU_OP_WIDTH-1:0] req1_op,
  input  logic [`CPU_WIDTH-1:0]    req1_src1,
  input  logic [`CPU_WIDTH-1:0]    req1_src2,
  output logic                     rsp0_valid,
  input  logic                     rsp0_ready,
  output logic                     rsp1_valid,
  input  logic                     rsp1_ready,
  output logic [`CPU_WIDTH-1:0]    rsp_res,
  output logic                     rsp_zero,
  output logic                     busy
);
  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic                    last_grant_q, last_grant_d;
  logic                    owner_q, owner_d;
  logic [`CPU_WIDTH-1:0]   rsp_res_q, rsp_res_d;
  logic                    rsp_zero_q, rsp_zero_d;
  logic                    grant_s, any_valid_s, can_accept_s, rsp_hs_s;
  logic [`ALU_OP_WIDTH-1:0] alu_op_s;
  logic [`CPU_WIDTH-1:0]   alu_src1_s, alu_src2_s, alu_res_s;
  logic                    alu_zero_s;

  // winner among valid requesters; a lone valid always wins
  always_comb begin
    grant_s = 1'b0;
    if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_RR_EN
      grant_s = ~last_grant_q;
`else
      grant_s = 1'b0;
`endif
    end else if (req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  assign any_valid_s  = req0_valid | req1_valid;
  // rst gates readies so a reset cycle never looks like an accepted handshake
  assign can_accept_s = (state_q == IDLE) && !rst && any_valid_s;
  assign req0_ready   = can_accept_s && !grant_s;
  assign req1_ready   = can_accept_s && grant_s;
  assign rsp_hs_s     = (state_q == RESP) && (owner_q ? rsp1_ready : rsp0_ready);

  assign alu_op_s   = grant_s ? req1_op   : req0_op;
  assign alu_src1_s = grant_s ? req1_src1 : req0_src1;
  assign alu_src2_s = grant_s ? req1_src2 : req0_src2;

  alu u_alu (
    .op_i   (alu_op_s),
    .src1_i (alu_src1_s),
    .src2_i (alu_src2_s),
    .res_o  (alu_res_s),
    .zero_o (alu_zero_s)
  );

  // next-state: capture on accept, release on response handshake
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    rsp_res_d    = rsp_res_q;
    rsp_zero_d   = rsp_zero_q;
    case (state_q)
      IDLE: begin
        if (can_accept_s) begin
          state_d      = RESP;
          owner_d      = grant_s;
          last_grant_d = grant_s;
          rsp_res_d    = alu_res_s;
          rsp_zero_d   = alu_zero_s;
        end else begin
          state_d = IDLE;
        end
      end
      RESP: begin
        if (rsp_hs_s) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      rsp_res_q    <= {`CPU_WIDTH{1'b0}};
      rsp_zero_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      rsp_res_q    <= rsp_res_d;
      rsp_zero_q   <= rsp_zero_d;
    end
  end

  assign busy       = (state_q == RESP);
  assign rsp0_valid = busy && !owner_q;
  assign rsp1_valid = busy && owner_q;
  assign rsp_res    = rsp_res_q;
  assign rsp_zero   = rsp_zero_q;
endmodule

// File: tb/tb_alu_arb.sv
// Scoreboard bench for alu_arb: transaction-level model predicts grants and results,
// a monitor compares every presented response against the expected queue.
module tb_alu_arb;
  localparam logic [3:0] OP_AND = 4'd0, OP_OR = 4'd1, OP_XOR = 4'd2, OP_ADD = 4'd3,
                         OP_SUB = 4'd4, OP_SLL = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7,
                         OP_SLT = 4'd8, OP_SLTU = 4'd9;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] req0_src1, req0_src2, req1_src1, req1_src2;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp_res;
  logic        rsp_zero, busy;

  always #5 clk = ~clk;

  alu_arb dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_src1(req0_src1), .req0_src2(req0_src2),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_src1(req1_src1), .req1_src2(req1_src2),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_res(rsp_res), .rsp_zero(rsp_zero), .busy(busy)
  );

  typedef struct {
    bit          owner;
    logic [31:0] res;
    bit          zero;
  } exp_t;

  exp_t        exp_q[$];
  int          dut_log[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          pv[2];
  logic [3:0]  p_op[2];
  logic [31:0] pa[2], pb[2];
  bit          rrdy[2];
  bit          rst_v;
  bit          m_busy = 1'b0, m_owner = 1'b0, m_last = 1'b1;

  function automatic logic [31:0] ref_alu(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    logic [63:0] wide;
    int          sh;
    sh = int'(b % 32);
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_ADD:  return 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
      OP_SUB:  return 32'((64'h1_0000_0000 + 64'(a) - 64'(b)) % 64'h1_0000_0000);
      OP_SLL:  begin wide = 64'(a) * (64'd1 << sh); return wide[31:0]; end
      OP_SRL:  return 32'(64'(a) / (64'd1 << sh));
      OP_SRA:  begin wide = {{32{a[31]}}, a}; wide = wide >> sh; return wide[31:0]; end
      OP_SLT:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      OP_SLTU: return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit pick();
    if (pv[0] && pv[1]) begin
`ifdef ALU_ARB_RR_EN
      return !m_last;
`else
      return 1'b0;
`endif
    end
    return pv[1];
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply();
    rst = rst_v;
    req0_valid = pv[0]; req0_op = p_op[0]; req0_src1 = pa[0]; req0_src2 = pb[0];
    req1_valid = pv[1]; req1_op = p_op[1]; req1_src1 = pa[1]; req1_src2 = pb[1];
    rsp0_ready = rrdy[0]; rsp1_ready = rrdy[1];
  endtask

  // model advances one clock using the inputs the DUT sampled at this edge
  task automatic model_step();
    bit w;
    exp_t e;
    if (rst_v) begin
      exp_q.delete();
      m_busy = 1'b0; m_last = 1'b1; m_owner = 1'b0;
    end else if (m_busy) begin
      if (rrdy[m_owner]) m_busy = 1'b0;
    end else if (pv[0] || pv[1]) begin
      w = pick();
      e.owner = w;
      e.res   = ref_alu(p_op[w], pa[w], pb[w]);
      e.zero  = (e.res == 32'd0);
      exp_q.push_back(e);
      pv[w] = 1'b0;
      m_busy = 1'b1; m_owner = w; m_last = w;
    end
  endtask

  task automatic cycle();
    bit any;
    apply();
    @(negedge clk);
    any = pv[0] || pv[1];
    check("busy", {31'd0, busy}, {31'd0, m_busy});
    check("req0_ready", {31'd0, req0_ready}, {31'd0, !rst_v && !m_busy && any && !pick()});
    check("req1_ready", {31'd0, req1_ready}, {31'd0, !rst_v && !m_busy && any && pick()});
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_req(int r, logic [3:0] op, logic [31:0] a, logic [31:0] b);
    pv[r] = 1'b1; p_op[r] = op; pa[r] = a; pb[r] = b;
  endtask

  task automatic drain();
    int i;
    rrdy[0] = 1'b1; rrdy[1] = 1'b1;
    for (i = 0; i < 40 && (m_busy || pv[0] || pv[1]); i++) cycle();
    if (m_busy || pv[0] || pv[1]) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: pending work after 40 cycles");
    end
    cycle();
  endtask

  task automatic run_op(logic [3:0] op, logic [31:0] a, logic [31:0] b, logic [31:0] exp_res,
                        string name);
    drain();
    set_req(0, op, a, b);
    cycle();
    check(name, rsp_res, exp_res);
    cycle();
  endtask

  // monitor: compare every presented response with the head of the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp0_valid || rsp1_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL rsp_unexpected: valid %b%b with empty scoreboard", rsp1_valid, rsp0_valid);
        end else begin
          e = exp_q[0];
          check("rsp_valid_pair", {30'd0, rsp1_valid, rsp0_valid}, e.owner ? 32'd2 : 32'd1);
          check("rsp_res", rsp_res, e.res);
          check("rsp_zero", {31'd0, rsp_zero}, {31'd0, e.zero});
          if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
            void'(exp_q.pop_front());
            dut_log.push_back(rsp1_valid ? 1 : 0);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      pv[i] = 1'b0; p_op[i] = 4'd0; pa[i] = 32'd0; pb[i] = 32'd0; rrdy[i] = 1'b0;
    end
    rst_v = 1'b1;
    cycle(); cycle();
    rst_v = 1'b0;
    cycle();
    check("reset_res", rsp_res, 32'd0);
    check("reset_zero", {31'd0, rsp_zero}, 32'd0);
    check("reset_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);

    // single add wraps into the sign bit
    set_req(0, OP_ADD, 32'h7FFF_FFFF, 32'h1); rrdy[0] = 1'b1; rrdy[1] = 1'b1;
    cycle();
    check("add_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    check("add_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    check("add_res", rsp_res, 32'h8000_0000);
    check("add_zero", {31'd0, rsp_zero}, 32'd0);

    // shifts and compares
    run_op(OP_SRA, 32'h8000_0000, 32'h24, 32'hF800_0000, "sra_res");
    run_op(OP_SLT, 32'hFFFF_FFFF, 32'h1, 32'd1, "slt_res");
    run_op(OP_SLTU, 32'hFFFF_FFFF, 32'h1, 32'd0, "sltu_res");
    run_op(4'd13, 32'h1234, 32'h5678, 32'd0, "undef_res");

    // backpressure on requester 1 while requester 0 waits
    drain();
    set_req(1, OP_SUB, 32'd5, 32'd5); rrdy[1] = 1'b0;
    cycle();
    set_req(0, OP_XOR, 32'hA5A5_0000, 32'h0000_5A5A);
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("bp_res", rsp_res, 32'd0);
      check("bp_zero", {31'd0, rsp_zero}, 32'd1);
      check("bp_busy", {31'd0, busy}, 32'd1);
      check("bp_req0_ready", {31'd0, req0_ready}, 32'd0);
    end
    rrdy[1] = 1'b1;
    cycle();
    check("bp_resume_ready", {31'd0, req0_ready}, 32'd1);
    cycle();
    check("bp_resume_valid", {31'd0, rsp0_valid}, 32'd1);

    // contention from reset with both requesters always valid
    drain();
    rst_v = 1'b1; cycle(); rst_v = 1'b0;
    dut_log.delete();
    for (int i = 0; i < 16; i++) begin
      if (!pv[0]) set_req(0, OP_ADD, $urandom, $urandom);
      if (!pv[1]) set_req(1, OP_OR, $urandom, $urandom);
      cycle();
    end
    if (dut_log.size() < 4) begin
      n_cmp++; n_bad++;
      $display("FAIL grant_seq_len: got %0d grants expected at least 4", dut_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_RR_EN
        check("grant_seq", dut_log[i], i % 2);
`else
        check("grant_seq", dut_log[i], 0);
`endif
      end
    end

    // reset while a result is held
    drain();
    set_req(0, OP_ADD, 32'd1, 32'd2); rrdy[0] = 1'b0; rrdy[1] = 1'b0;
    cycle(); cycle();
    check("mid_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    set_req(0, OP_AND, 32'hFF00_FF00, 32'h0F0F_0F0F);
    set_req(1, OP_OR, 32'h1, 32'h2);
    rst_v = 1'b1;
    cycle();
    rst_v = 1'b0;
    check("rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    check("rst_res", rsp_res, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    cycle();
    check("rst_first_grant", {30'd0, rsp1_valid, rsp0_valid}, 32'd1);

    // randomized traffic
    drain();
    for (int i = 0; i < 400; i++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pv[r] && $urandom_range(0, 2) != 0)
          set_req(r, ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                 : 4'($urandom_range(0, 9)),
                  ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom, $urandom);
        rrdy[r] = ($urandom_range(0, 3) != 0);
      end
      cycle();
    end
    drain();
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_arb.md
ALU_ARB -- requirements
Module: alu_arb

Interface
REQ-001 No parameters; data width SHALL be `CPU_WIDTH (32) and opcode width `ALU_OP_WIDTH, both from rvseed_defines.v.
REQ-002 clk  input  1  system clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req0_valid / req1_valid  input  1  requester n presents an ALU operation.
REQ-005 req0_ready / req1_ready  output  1  arbiter accepts requester n's operation this cycle.
REQ-006 req0_op / req1_op  input  `ALU_OP_WIDTH  ALU opcode (ALU_AND..ALU_SLTU).
REQ-007 req0_src1, req0_src2 / req1_src1, req1_src2  input  `CPU_WIDTH  operands.
REQ-008 rsp0_valid / rsp1_valid  output  1  result for requester n available.
REQ-009 rsp0_ready / rsp1_ready  input  1  requester n consumes result.
REQ-010 rsp_res  output  `CPU_WIDTH  registered result, shared by both response channels.
REQ-011 rsp_zero  output  1  registered zero flag (rsp_res == 0).
REQ-012 busy  output  1  high while a result is held (state RESP).

Function
REQ-013 Block SHALL contain exactly one alu instance shared by both requesters; requests SHALL be served one at a time.
REQ-014 FSM SHALL have two states: IDLE (may accept) and RESP (result held, no acceptance).
REQ-015 In IDLE, req_n_ready SHALL be 1 only for the granted requester among those with valid high; both readies 0 in RESP and when no valid is high.
REQ-016 Ready MAY depend combinationally on valid; valid SHALL NOT depend on ready.
REQ-017 Accept = req_n_valid & req_n_ready; on accept, op/src1/src2 of the winner drive the alu that cycle and alu_res/zero SHALL be captured into rsp_res/rsp_zero, owner index captured, FSM -> RESP.
REQ-018 Latency: rsp_n_valid SHALL assert in the cycle after accept (1-cycle latency) only for the owner; the other rsp valid stays 0.
REQ-019 rsp_res, rsp_zero and rsp_n_valid SHALL remain stable in RESP until rsp_n_ready is sampled high.
REQ-020 On response handshake, FSM -> IDLE next cycle; new request accepted no earlier than that cycle (max throughput one op / 2 cycles).
REQ-021 Response backpressure: rsp_n_ready low for any number of cycles SHALL hold RESP; pending requests from both requesters wait (ready 0).
REQ-022 ALU semantics: AND/OR/XOR/ADD/SUB modulo 2^32; SLL/SRL/SRA use src2[4:0]; SLT signed, SLTU unsigned, result 0/1; undefined opcode yields rsp_res 0, rsp_zero 1.
REQ-023 Arbitration state last_grant (1 bit) SHALL update to the winner index only on accept.
REQ-024 Only one valid high: that requester SHALL be granted regardless of last_grant.

Reset
REQ-025 On rst high at a clock edge: FSM = IDLE, last_grant = 1, rsp_res = 0, rsp_zero = 0, owner = 0, both rsp valids 0, busy 0, both readies 0 the following cycle unless valid.
REQ-026 Reset in RESP SHALL discard the held result; no rsp_n_valid after reset until a new accept.
REQ-027 rst SHALL take priority over any simultaneous accept or response handshake.

Configuration
REQ-028 Macro ALU_ARB_RR_EN defined: both valid in IDLE -> grant requester != last_grant (round-robin, alternating).
REQ-029 ALU_ARB_RR_EN undefined: both valid -> requester 0 always granted (fixed priority); last_grant kept but unused for selection.

Verification
REQ-030 Single op: req0 ALU_ADD 0x7FFFFFFF + 0x1 -> next cycle rsp0_valid=1, rsp_res=0x80000000, rsp_zero=0, rsp1_valid=0.
REQ-031 Contention with RR: both valid continuously, rsp_ready=1, after reset -> grants 0,1,0,1; without macro -> grants 0,0,0,0, req1 starved.
REQ-032 Backpressure: req1 ALU_SUB 5-5, rsp1_ready low 4 cycles -> rsp_res=0, rsp_zero=1 stable, busy=1, req0_ready=0 throughout; accept resumes cycle after handshake.
REQ-033 Shift/compare: SRA 0x80000000 by src2=0x24 -> 0xF8000000; SLT 0xFFFFFFFF vs 1 -> 1; SLTU same -> 0.
REQ-034 Reset mid-RESP: rst high while rsp0_valid=1 -> next cycle rsp0_valid=0, rsp_res=0, busy=0; next both-valid grant is requester 0.
